twire_slave_rsp: RTL and testbench

- Synthesizable two-wire (I2C/SCCB-style) slave responder: the sensor-side end of the bus the twire master drives.
- Decodes START, STOP and repeated START; matches the device address (write form 0x20, read form 0x21); ACKs; takes an 8-bit register pointer.
- Write transactions produce register-write strobes; read transactions return register data over SDA. Pointer auto-increments.
- Used as an RTL sensor model in benches and as a reusable slave front end; sits between the bus pads and a user register file.

---
 rtl/twire_slave_rsp.sv | 210 +++++++++++++++++++++
 tb/tb_twire_slave_rsp.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twire_slave_rsp.sv
// Two-wire (I2C/SCCB-style) slave responder: decodes START/STOP, matches the device
// address and bridges received/transmitted bytes to a simple register-file port.
module twire_slave_rsp #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h10,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK,
        RD_LOAD, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             rx_q, rx_d;
    logic [7:0]             tx_q, tx_d;
    logic                   rw_q, rw_d;
    logic [1:0]             ld_q, ld_d;
    logic                   sda_oe_q, sda_oe_d;
    logic [7:0]             reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
    logic                   reg_we_q, reg_we_d, reg_re_q, reg_re_d, busy_q, busy_d;

    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {rx_q, sda_s};

    always_comb begin
        state_d     = state_q;
        scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_prev_d  = scl_s;
        sda_prev_d  = sda_s;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        ld_d        = ld_q;
        sda_oe_d    = sda_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        busy_d      = busy_q;

        // The pointer advances the cycle after a write strobe so the strobe carries the old address.
        if (reg_we_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
        end

        if (start_det) begin
            state_d   = DEV_ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                DEV_ADDR, REG_ADDR, WR_DATA: begin
                    if (scl_rise) begin
                        rx_d      = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == DEV_ADDR) begin
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    state_d = DEV_ACK;
                                    busy_d  = 1'b1;
                                    rw_d    = rx_byte[0];
                                end else begin
                                    state_d = WAIT_STOP;
                                end
                            end else if (state_q == REG_ADDR) begin
                                reg_addr_d = rx_byte;
                                state_d    = REG_ACK;
                            end else begin
                                reg_wdata_d = rx_byte;
                                reg_we_d    = 1'b1;
                                state_d     = WR_ACK;
                            end
                        end
                    end
                end
                // ACK slot: first fall pulls SDA low, second fall releases it and ends the slot.
                DEV_ACK, REG_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = (state_q == DEV_ACK) ? REG_ADDR : WR_DATA;
                        end
                    end else if (scl_rise && state_q == DEV_ACK && rw_q && sda_oe_q) begin
                        state_d = RD_LOAD;
                        ld_d    = 2'd0;
                    end
                end
                // Request, wait one cycle for the user file, capture, then drive MSB on the next fall.
                RD_LOAD: begin
                    if (ld_q == 2'd0) begin
                        reg_re_d = 1'b1;
                        ld_d     = 2'd1;
                    end else if (ld_q == 2'd1) begin
                        ld_d = 2'd2;
                    end else if (ld_q == 2'd2) begin
                        tx_d = reg_rdata;
                        ld_d = 2'd3;
                    end else if (scl_fall) begin
                        sda_oe_d  = ~tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b0};
                        bit_cnt_d = 3'd0;
                        state_d   = RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        sda_oe_d = ~tx_q[7];
                        tx_d     = {tx_q[6:0], 1'b0};
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = RD_ACK;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        reg_addr_d = reg_addr_q + 8'd1;
                        if (!sda_s) begin
                            state_d = RD_LOAD;
                            ld_d    = 2'd0;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 7'd0;
            tx_q        <= 8'd0;
            rw_q        <= 1'b0;
            ld_q        <= 2'd0;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= 8'd0;
            reg_wdata_q <= 8'd0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            ld_q        <= ld_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_twire_slave_rsp.sv
// Bench for twire_slave_rsp: bus-master tasks, a registered user register file,
// and a byte-level reference model (memory image + pointer) for the expected traffic.
module tb_twire_slave_rsp;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       mem_init = 1'b0;
    logic       sda_line;
    logic       sda_oe, reg_we, reg_re, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata, rd_q;
    logic [7:0] uf_mem [256];

    logic [7:0]  model_mem [256];
    logic [7:0]  model_ptr;
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;

    int n_vec = 0;
    int n_err = 0;
    int re_cnt = 0;
    int we_cnt = 0;
    logic oe_seen = 1'b0;
    logic busy_seen = 1'b0;

    assign sda_line  = sda_m & ~sda_oe;
    assign reg_rdata = rd_q;

    twire_slave_rsp #(.SLAVE_ADDR(7'h10), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // User register file: read data returned on the clk after reg_re.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) uf_mem[i] <= init_val(i);
        end else if (reg_we) begin
            uf_mem[reg_addr] <= reg_wdata;
        end
        if (reg_re) rd_q <= uf_mem[reg_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every write strobe must match the head of exp_q.
    always @(negedge clk) begin
        if (!rst) begin
            if (reg_we) begin
                we_cnt++;
                check("we_re_excl", 32'(reg_re), 32'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_we: got addr 0x%0h data 0x%0h, expected no write", reg_addr, reg_wdata);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("we_addr_data", 32'({reg_addr, reg_wdata}), 32'(exp_w));
                end
            end
            if (reg_re) re_cnt++;
            if (sda_oe) oe_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic wait_q();
        repeat (Q) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic bit_cycle(input logic b, output logic r);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q();
        r = sda_line; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], r);
        bit_cycle(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic ack_m, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, r);
            d[i] = r;
        end
        bit_cycle(~ack_m, r);
    endtask

    task automatic model_write(input logic [7:0] d);
        exp_q.push_back({model_ptr, d});
        model_mem[model_ptr] = d;
        model_ptr = model_ptr + 8'd1;
    endtask

    // Read burst after the address phase: master ACKs all but the last byte.
    task automatic do_read(input int len);
        logic       ack;
        logic [7:0] d;
        logic [7:0] exp_d;
        int         re0;
        re0 = re_cnt;
        write_byte(8'h21, ack);
        check("rd_dev_ack", 32'(ack), 32'd1);
        for (int i = 0; i < len; i++) begin
            exp_d = model_mem[model_ptr];
            model_ptr = model_ptr + 8'd1;
            read_byte(i < len - 1, d);
            check("rd_data", 32'(d), 32'(exp_d));
        end
        bus_stop();
        check("rd_re_count", 32'(re_cnt - re0), 32'(len));
        check("rd_ptr", 32'(reg_addr), 32'(model_ptr));
        check("rd_busy_idle", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [7:0] ptr, d0, d1, a0, a1, end_ptr;
    } wvec_t;

    initial begin : main
        wvec_t      wtab [4];
        logic       ack, r;
        logic [7:0] d0, d1, ptr;
        int         re0, we0, kind, len;

        wtab[0] = '{8'h05, 8'hA5, 8'h3C, 8'h05, 8'h06, 8'h07};
        wtab[1] = '{8'hFF, 8'h11, 8'h22, 8'hFF, 8'h00, 8'h01};
        wtab[2] = '{8'h07, 8'h5A, 8'hC3, 8'h07, 8'h08, 8'h09};
        wtab[3] = '{8'h30, 8'h12, 8'h80, 8'h30, 8'h31, 8'h32};

        // Clock/reset
        for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
        model_ptr = 8'h00;
        rst = 1'b1;
        mem_init = 1'b1;
        repeat (4) @(posedge clk);
        mem_init = 1'b0;
        @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        check("rst_reg_we", 32'(reg_we), 32'd0);
        check("rst_reg_re", 32'(reg_re), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Table-driven write bursts
        for (int v = 0; v < 4; v++) begin
            bus_start();
            write_byte(8'h20, ack);
            check("wr_dev_ack", 32'(ack), 32'd1);
            check("wr_busy_set", 32'(busy), 32'd1);
            write_byte(wtab[v].ptr, ack);
            check("wr_ptr_ack", 32'(ack), 32'd1);
            exp_q.push_back({wtab[v].a0, wtab[v].d0});
            exp_q.push_back({wtab[v].a1, wtab[v].d1});
            model_mem[wtab[v].a0] = wtab[v].d0;
            model_mem[wtab[v].a1] = wtab[v].d1;
            write_byte(wtab[v].d0, ack);
            check("wr_d0_ack", 32'(ack), 32'd1);
            write_byte(wtab[v].d1, ack);
            check("wr_d1_ack", 32'(ack), 32'd1);
            bus_stop();
            check("wr_busy_clr", 32'(busy), 32'd0);
            check("wr_end_ptr", 32'(reg_addr), 32'(wtab[v].end_ptr));
            check("wr_all_strobes", 32'(exp_q.size()), 32'd0);
            model_ptr = wtab[v].end_ptr;
        end

        // Random read with repeated START: 0x5A@0x07, 0xC3@0x08
        bus_start();
        write_byte(8'h20, ack);
        write_byte(8'h07, ack);
        check("rr_ptr_ack", 32'(ack), 32'd1);
        bus_start();
        re0 = re_cnt;
        write_byte(8'h21, ack);
        check("rr_dev_ack", 32'(ack), 32'd1);
        read_byte(1'b1, d0);
        read_byte(1'b0, d1);
        bus_stop();
        check("rr_byte0", 32'(d0), 32'h5A);
        check("rr_byte1", 32'(d1), 32'hC3);
        check("rr_re_count", 32'(re_cnt - re0), 32'd2);
        check("rr_ptr", 32'(reg_addr), 32'h09);
        model_ptr = 8'h09;

        // Address mismatch: never drives SDA, no strobes, never busy
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        re0 = re_cnt;
        we0 = we_cnt;
        bus_start();
        write_byte(8'h42, ack);
        check("mm_nack", 32'(ack), 32'd0);
        for (int i = 0; i < 8; i++) write_byte(8'($urandom_range(0, 255)), ack);
        bus_stop();
        check("mm_oe_seen", 32'(oe_seen), 32'd0);
        check("mm_busy_seen", 32'(busy_seen), 32'd0);
        check("mm_re", 32'(re_cnt - re0), 32'd0);
        check("mm_we", 32'(we_cnt - we0), 32'd0);
        check("mm_ptr", 32'(reg_addr), 32'(model_ptr));

        // Abort with STOP after four data bits
        we0 = we_cnt;
        bus_start();
        write_byte(8'h20, ack);
        write_byte(8'h40, ack);
        bit_cycle(1'b1, r); bit_cycle(1'b0, r); bit_cycle(1'b1, r); bit_cycle(1'b0, r);
        bus_stop();
        model_ptr = 8'h40;
        check("ab_we", 32'(we_cnt - we0), 32'd0);
        check("ab_sda_oe", 32'(sda_oe), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_ptr", 32'(reg_addr), 32'h40);
        bus_start();
        write_byte(8'h20, ack);
        check("ab_next_ack", 32'(ack), 32'd1);
        write_byte(8'h50, ack);
        model_ptr = 8'h50;
        model_write(8'h99);
        write_byte(8'h99, ack);
        check("ab_next_data_ack", 32'(ack), 32'd1);
        bus_stop();
        check("ab_next_ptr", 32'(reg_addr), 32'h51);
        check("ab_next_strobes", 32'(exp_q.size()), 32'd0);

        // Reset while driving a 0 data bit (0x12 at 0x30)
        bus_start();
        write_byte(8'h20, ack);
        write_byte(8'h30, ack);
        bus_start();
        write_byte(8'h21, ack);
        check("rs_dev_ack", 32'(ack), 32'd1);
        check("rs_msb_driven", 32'(sda_oe), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rs_sda_oe", 32'(sda_oe), 32'd0);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_reg_addr", 32'(reg_addr), 32'd0);
        check("rs_reg_wdata", 32'(reg_wdata), 32'd0);
        check("rs_reg_we", 32'(reg_we), 32'd0);
        check("rs_reg_re", 32'(reg_re), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 8'h00;
        repeat (4) @(posedge clk);
        bus_start();
        write_byte(8'h20, ack);
        check("rs_after_ack", 32'(ack), 32'd1);
        bus_stop();
        check("rs_after_busy", 32'(busy), 32'd0);

        // Randomized transactions against the reference model
        for (int t = 0; t < 16; t++) begin
            kind = $urandom_range(0, 2);
            len  = $urandom_range(1, 3);
            ptr  = 8'($urandom_range(0, 255));
            bus_start();
            if (kind == 2) begin
                do_read(len);
            end else begin
                write_byte(8'h20, ack);
                check("rnd_dev_ack", 32'(ack), 32'd1);
                write_byte(ptr, ack);
                check("rnd_ptr_ack", 32'(ack), 32'd1);
                model_ptr = ptr;
                if (kind == 1) begin
                    bus_start();
                    do_read(len);
                end else begin
                    for (int i = 0; i < len; i++) begin
                        d0 = 8'($urandom_range(0, 255));
                        model_write(d0);
                        write_byte(d0, ack);
                        check("rnd_data_ack", 32'(ack), 32'd1);
                    end
                    bus_stop();
                    check("rnd_wr_ptr", 32'(reg_addr), 32'(model_ptr));
                    check("rnd_wr_strobes", 32'(exp_q.size()), 32'd0);
                    check("rnd_wr_busy", 32'(busy), 32'd0);
                end
            end
        end

        repeat (10) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
